// File: rtl/uart_parity_engine.sv
// -----------------------------------------------------------------------------
// uart_parity_engine
//   Parity engine for the UART datapath.
//   TX side: captures a parallel word on Data_Valid && !busy and produces the
//   frame parity bit one clock later (par_bit held, par_valid single-cycle pulse).
//   RX side: accumulates deserialised data bits for the current frame, compares
//   the received parity bit and raises a sticky par_err (chk_done pulses).
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   par_en          parity enabled for the frame being captured / started
//   par_mode        00 even, 01 odd, 10 mark, 11 space
//   data_len        valid data bits (1..DATA_WIDTH, otherwise DATA_WIDTH)
//   P_DATA          TX parallel data
//   Data_Valid      TX word offered
//   busy            serializer busy, blocks capture
//   par_bit         TX parity bit of the last captured frame
//   par_valid       1-cycle pulse when par_bit is updated with parity enabled
//   rx_start        start of RX frame (clears accumulator, latches config)
//   rx_bit_valid    rx_bit carries a data bit
//   rx_bit          RX data bit
//   rx_par_sample   rx_par_bit carries the received parity bit
//   rx_par_bit      received parity bit
//   par_err         sticky parity/length error of the current RX frame
//   chk_done        1-cycle pulse when par_err is updated by a check
// -----------------------------------------------------------------------------
module uart_parity_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  par_en,
   input  logic [1:0]            par_mode,
   input  logic [LEN_W-1:0]      data_len,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  busy,
   output logic                  par_bit,
   output logic                  par_valid,
   input  logic                  rx_start,
   input  logic                  rx_bit_valid,
   input  logic                  rx_bit,
   input  logic                  rx_par_sample,
   input  logic                  rx_par_bit,
   output logic                  par_err,
   output logic                  chk_done
);

   localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(DATA_WIDTH);
   localparam logic [1:0]       MODE_EVEN  = 2'b00;
   localparam logic [1:0]       MODE_ODD   = 2'b01;
   localparam logic [1:0]       MODE_MARK  = 2'b10;
   localparam logic [1:0]       MODE_SPACE = 2'b11;
   localparam logic [0:0]       ST_IDLE    = 1'b0;
   localparam logic [0:0]       ST_ACC     = 1'b1;

   // Parity of a frame given the XOR of its (masked) data bits.
   function automatic logic par_fn(input logic x, input logic [1:0] mode);
      logic p;
      case (mode)
         MODE_EVEN:  p = x;
         MODE_ODD:   p = ~x;
         MODE_MARK:  p = 1'b1;
         MODE_SPACE: p = 1'b0;
         default:    p = 1'b0;
      endcase
      return p;
   endfunction

   // Out-of-range lengths (0 or above DATA_WIDTH) mean a full-width frame.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
      logic [LEN_W-1:0] r;
      if ((l >= LEN_W'(1)) && (l <= FULL_LEN)) begin
         r = l;
      end else begin
         r = FULL_LEN;
      end
      return r;
   endfunction

   // Clear every bit at index >= len.
   function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [LEN_W-1:0]      len);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (LEN_W'(i) < len) begin
            m[i] = d[i];
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // ---------------------------------------------------------------- TX path
   logic                  capture_s;
   logic [DATA_WIDTH-1:0] masked_s;
   logic                  tx_par_s;
   logic                  par_bit_r;
   logic                  par_valid_r;

   // TX parity of the word currently offered.
   always_comb begin
      capture_s = Data_Valid & ~busy;
      masked_s  = mask_data(P_DATA, eff_len(data_len));
      tx_par_s  = par_fn(^masked_s, par_mode);
   end

   // TX capture register: par_bit holds between captures, par_valid pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit_r   <= 1'b0;
         par_valid_r <= 1'b0;
      end else if (capture_s) begin
         if (par_en) begin
            par_bit_r   <= tx_par_s;
            par_valid_r <= 1'b1;
         end else begin
            par_bit_r   <= 1'b0;
            par_valid_r <= 1'b0;
         end
      end else begin
         par_valid_r <= 1'b0;
      end
   end

   assign par_bit   = par_bit_r;
   assign par_valid = par_valid_r;

   // ---------------------------------------------------------------- RX path
   logic [0:0]       state_r,   state_nxt_s;
   logic             acc_r,     acc_nxt_s;
   logic [LEN_W-1:0] cnt_r,     cnt_nxt_s;
   logic             err_r,     err_nxt_s;
   logic             done_r,    done_nxt_s;
   logic             cfg_en_r,  cfg_en_nxt_s;
   logic [1:0]       cfg_mode_r, cfg_mode_nxt_s;
   logic [LEN_W-1:0] cfg_len_r, cfg_len_nxt_s;
   logic             acc_bit_s;
   logic [LEN_W-1:0] cnt_bit_s;

   // RX next-state: a data bit arriving with the parity sample is folded in
   // first (acc_bit_s/cnt_bit_s) so the check sees the complete frame.
   always_comb begin
      state_nxt_s    = state_r;
      acc_nxt_s      = acc_r;
      cnt_nxt_s      = cnt_r;
      err_nxt_s      = err_r;
      done_nxt_s     = 1'b0;
      cfg_en_nxt_s   = cfg_en_r;
      cfg_mode_nxt_s = cfg_mode_r;
      cfg_len_nxt_s  = cfg_len_r;
      acc_bit_s      = acc_r;
      cnt_bit_s      = cnt_r;

      if (rx_bit_valid && (cnt_r < cfg_len_r)) begin
         acc_bit_s = acc_r ^ rx_bit;
         cnt_bit_s = cnt_r + LEN_W'(1);
      end else begin
         acc_bit_s = acc_r;
         cnt_bit_s = cnt_r;
      end

      if (rx_start) begin
         state_nxt_s    = ST_ACC;
         err_nxt_s      = 1'b0;
         cfg_en_nxt_s   = par_en;
         cfg_mode_nxt_s = par_mode;
         cfg_len_nxt_s  = eff_len(data_len);
         if (rx_bit_valid) begin
            acc_nxt_s = rx_bit;
            cnt_nxt_s = LEN_W'(1);
         end else begin
            acc_nxt_s = 1'b0;
            cnt_nxt_s = '0;
         end
      end else if (state_r == ST_ACC) begin
         acc_nxt_s = acc_bit_s;
         cnt_nxt_s = cnt_bit_s;
         if (rx_par_sample) begin
            state_nxt_s = ST_IDLE;
            if (cfg_en_r) begin
               err_nxt_s  = (rx_par_bit != par_fn(acc_bit_s, cfg_mode_r)) |
                            (cnt_bit_s != cfg_len_r);
               done_nxt_s = 1'b1;
            end else begin
               err_nxt_s  = 1'b0;
               done_nxt_s = 1'b0;
            end
         end else begin
            state_nxt_s = ST_ACC;
         end
      end else begin
         state_nxt_s = ST_IDLE;
      end
   end

   // RX state, accumulator, latched frame config and check outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         acc_r      <= 1'b0;
         cnt_r      <= '0;
         err_r      <= 1'b0;
         done_r     <= 1'b0;
         cfg_en_r   <= 1'b1;
         cfg_mode_r <= MODE_EVEN;
         cfg_len_r  <= FULL_LEN;
      end else begin
         state_r    <= state_nxt_s;
         acc_r      <= acc_nxt_s;
         cnt_r      <= cnt_nxt_s;
         err_r      <= err_nxt_s;
         done_r     <= done_nxt_s;
         cfg_en_r   <= cfg_en_nxt_s;
         cfg_mode_r <= cfg_mode_nxt_s;
         cfg_len_r  <= cfg_len_nxt_s;
      end
   end

   assign par_err  = err_r;
   assign chk_done = done_r;

endmodule

// File: tb/tb_uart_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_parity_engine
//   Directed self-checking bench for uart_parity_engine (DATA_WIDTH = 8).
//   Inputs change #1 after a rising edge; outputs are sampled #1 after the
//   following rising edge.
// -----------------------------------------------------------------------------
module tb_uart_parity_engine;

   logic       clk;
   logic       rst_n;
   logic       par_en;
   logic [1:0] par_mode;
   logic [3:0] data_len;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       busy;
   logic       par_bit;
   logic       par_valid;
   logic       rx_start;
   logic       rx_bit_valid;
   logic       rx_bit;
   logic       rx_par_sample;
   logic       rx_par_bit;
   logic       par_err;
   logic       chk_done;

   int n_tests;
   int n_fail;

   uart_parity_engine #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .par_en        (par_en),
      .par_mode      (par_mode),
      .data_len      (data_len),
      .P_DATA        (P_DATA),
      .Data_Valid    (Data_Valid),
      .busy          (busy),
      .par_bit       (par_bit),
      .par_valid     (par_valid),
      .rx_start      (rx_start),
      .rx_bit_valid  (rx_bit_valid),
      .rx_bit        (rx_bit),
      .rx_par_sample (rx_par_sample),
      .rx_par_bit    (rx_par_bit),
      .par_err       (par_err),
      .chk_done      (chk_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send n data bits of v, LSB first, one per cycle.
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         rx_bit_valid = 1'b1;
         rx_bit       = v[i];
         tick();
      end
      rx_bit_valid = 1'b0;
      rx_bit       = 1'b0;
   endtask

   task automatic start_frame();
      rx_start = 1'b1;
      tick();
      rx_start = 1'b0;
   endtask

   task automatic sample(input logic pbit);
      rx_par_sample = 1'b1;
      rx_par_bit    = pbit;
      tick();
      rx_par_sample = 1'b0;
      rx_par_bit    = 1'b0;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      par_en        = 1'b1;
      par_mode      = 2'b00;
      data_len      = 4'd8;
      P_DATA        = 8'h00;
      Data_Valid    = 1'b0;
      busy          = 1'b0;
      rx_start      = 1'b0;
      rx_bit_valid  = 1'b0;
      rx_bit        = 1'b0;
      rx_par_sample = 1'b0;
      rx_par_bit    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_par_bit",   par_bit,   1'b0);
      check("rst_par_valid", par_valid, 1'b0);
      check("rst_par_err",   par_err,   1'b0);
      check("rst_chk_done",  chk_done,  1'b0);
      rst_n = 1'b1;
      tick();

      // 1: even, len 8, 8'hA7 (five ones) -> 1
      P_DATA = 8'hA7; Data_Valid = 1'b1;
      tick();
      check("t1_bit",   par_bit,   1'b1);
      check("t1_valid", par_valid, 1'b1);
      Data_Valid = 1'b0;
      tick();
      check("t1_pulse_end", par_valid, 1'b0);
      check("t1_hold",      par_bit,   1'b1);

      // 2: odd, offered while busy -> ignored, then captured -> 0
      par_mode = 2'b01; Data_Valid = 1'b1; busy = 1'b1;
      tick();
      check("t2_busy_valid", par_valid, 1'b0);
      check("t2_busy_bit",   par_bit,   1'b1);
      busy = 1'b0;
      tick();
      check("t2_bit",   par_bit,   1'b0);
      check("t2_valid", par_valid, 1'b1);

      // 3: length masking, back-to-back captures
      par_mode = 2'b00; data_len = 4'd5; P_DATA = 8'hF3;
      tick();
      check("t3_len5_bit", par_bit, 1'b1);
      data_len = 4'd0; P_DATA = 8'h80;
      tick();
      check("t3_len0_bit",   par_bit,   1'b1);
      check("t3_len0_valid", par_valid, 1'b1);
      data_len = 4'd9; P_DATA = 8'h81;
      tick();
      check("t3_len9_bit",   par_bit,   1'b0);
      check("t3_len9_valid", par_valid, 1'b1);
      data_len = 4'd1; P_DATA = 8'hFF;
      tick();
      check("t3_len1_bit", par_bit, 1'b1);

      // 4: mark / space / disabled
      data_len = 4'd8; par_mode = 2'b10; P_DATA = 8'h00;
      tick();
      check("t4_mark", par_bit, 1'b1);
      par_mode = 2'b11; P_DATA = 8'hFF;
      tick();
      check("t4_space", par_bit, 1'b0);
      par_mode = 2'b10;
      tick();
      check("t4_mark2", par_bit, 1'b1);
      par_en = 1'b0;
      tick();
      check("t4_dis_bit",   par_bit,   1'b0);
      check("t4_dis_valid", par_valid, 1'b0);
      Data_Valid = 1'b0; par_en = 1'b1;
      tick();

      // 5: RX even len 8, bits of 8'h0F
      par_mode = 2'b00; data_len = 4'd8;
      start_frame();
      send_bits(8'h0F, 8);
      sample(1'b0);
      check("t5_ok_done", chk_done, 1'b1);
      check("t5_ok_err",  par_err,  1'b0);
      tick();
      check("t5_done_pulse", chk_done, 1'b0);
      start_frame();
      send_bits(8'h0F, 8);
      sample(1'b1);
      check("t5_bad_done", chk_done, 1'b1);
      check("t5_bad_err",  par_err,  1'b1);
      tick();
      check("t5_sticky", par_err, 1'b1);
      sample(1'b0);
      check("t5_idle_sample_done", chk_done, 1'b0);
      check("t5_idle_sample_err",  par_err,  1'b1);

      // RX odd: first bit with rx_start, last bit with the parity sample
      par_mode = 2'b01; rx_start = 1'b1; rx_bit_valid = 1'b1; rx_bit = 1'b1;
      tick();
      rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
      check("rx_start_clr_err", par_err, 1'b0);
      send_bits(8'h00, 6);
      rx_bit_valid = 1'b1; rx_bit = 1'b0;
      sample(1'b0);
      rx_bit_valid = 1'b0;
      check("rx_same_cycle_done", chk_done, 1'b1);
      check("rx_same_cycle_err",  par_err,  1'b0);

      // RX len 3: fourth bit ignored
      par_mode = 2'b00; data_len = 4'd3;
      start_frame();
      send_bits(8'b0000_1011, 4);
      sample(1'b0);
      check("rx_len3_done", chk_done, 1'b1);
      check("rx_len3_err",  par_err,  1'b0);

      // RX with parity disabled: no pulse, no error
      par_en = 1'b0; data_len = 4'd8;
      start_frame();
      send_bits(8'h01, 8);
      sample(1'b0);
      check("rx_dis_done", chk_done, 1'b0);
      check("rx_dis_err",  par_err,  1'b0);
      par_en = 1'b1;

      // 6: short frame (6 of 8) -> error; TX mark capture in the same cycle
      start_frame();
      send_bits(8'h00, 6);
      par_mode = 2'b10; Data_Valid = 1'b1;
      sample(1'b0);
      Data_Valid = 1'b0;
      check("t6_short_done",  chk_done,  1'b1);
      check("t6_short_err",   par_err,   1'b1);
      check("t6_tx_bit",      par_bit,   1'b1);
      check("t6_tx_valid",    par_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_arst_par_bit",   par_bit,   1'b0);
      check("t6_arst_par_valid", par_valid, 1'b0);
      check("t6_arst_par_err",   par_err,   1'b0);
      check("t6_arst_chk_done",  chk_done,  1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      sample(1'b1);
      check("post_rst_idle_done", chk_done, 1'b0);
      check("post_rst_idle_err",  par_err,  1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
